// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep/capture block.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_e;

  localparam int TT_BITS   = 128;
  localparam int TT_WORDS  = 4;
  localparam int TT_WORD_W = 32;
  localparam int TT_IDX_W  = 2;

  // Word k covers table bits [32k+31 : 32k].
  function automatic logic [TT_WORD_W-1:0] word_slice(input logic [TT_BITS-1:0] tbl,
                                                      input logic [TT_IDX_W-1:0] k);
    return tbl[{k, 5'd0} +: TT_WORD_W];
  endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Word stream carrying the captured truth table, valid/ready handshake.
interface tt_sweep_capture_if;
  import tt_pkg::*;

  logic                  word_valid;
  logic                  word_ready;
  logic [TT_WORD_W-1:0]  word_data;
  logic [TT_IDX_W-1:0]   word_idx;

  modport master (output word_valid, output word_data, output word_idx, input word_ready);
  modport slave  (input word_valid, input word_data, input word_idx, output word_ready);
endinterface

// File: rtl/tt_word_emitter.sv
// Streams the captured table as words, highest index first, through a registered valid/ready slice.
module tt_word_emitter
  import tt_pkg::*;
#(
  parameter int NWORDS = TT_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TT_BITS-1:0] tbl,
  output logic               last_hs,
  tt_sweep_capture_if.master wif
);

  localparam logic [TT_IDX_W-1:0] LAST_IDX = TT_IDX_W'(NWORDS - 1);

  logic                 valid_q;
  logic [TT_IDX_W-1:0]  idx_q;
  logic [TT_WORD_W-1:0] data_q;
  logic                 hs;

  assign hs      = valid_q & wif.word_ready;
  assign last_hs = hs && (idx_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= LAST_IDX;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      idx_q   <= LAST_IDX;
      data_q  <= word_slice(tbl, LAST_IDX);
    end else if (hs) begin
      if (idx_q == '0) begin
        valid_q <= 1'b0;
      end else begin
        idx_q  <= idx_q - 2'd1;
        data_q <= word_slice(tbl, idx_q - 2'd1);
      end
    end
  end

  assign wif.word_valid = valid_q;
  assign wif.word_data  = data_q;
  assign wif.word_idx   = idx_q;

endmodule

// File: rtl/tt_sweep_capture.sv
// Enumerates all 7-bit input vectors, samples the function output into a 128-bit table, then streams it out.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int NUM_INPUTS    = 7,
  parameter int SETTLE_CYCLES = 1,
  parameter int WORD_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [NUM_INPUTS-1:0] x,
  input  logic                  f_in,
  output logic                  busy,
  output logic [7:0]            ones_count,
  output logic                  done,
  tt_sweep_capture_if.master    wif
);

  localparam logic [3:0]            SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [NUM_INPUTS-1:0] X_ONE       = 1;

  state_e                state_q;
  logic [NUM_INPUTS-1:0] x_q;
  logic [3:0]            cnt_q;
  logic [TT_BITS-1:0]    table_q;
  logic [TT_BITS-1:0]    table_d;
  logic [7:0]            ones_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sample;
  logic                  load;
  logic                  last_hs;

  assign sample = (state_q == SETTLE) && (cnt_q == SETTLE_LAST);
  assign load   = sample && (&x_q);

  // The emitter sees the next-state table so the final sampled bit lands in word 3 on EMIT entry.
  always_comb begin
    table_d = table_q;
    if (sample) table_d[x_q] = f_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETTLE;
            x_q     <= '0;
            cnt_q   <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (sample) begin
            table_q <= table_d;
            ones_q  <= ones_q + {7'd0, f_in};
            if (&x_q) begin
              state_q <= EMIT;
            end else begin
              x_q   <= x_q + X_ONE;
              cnt_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        EMIT: begin
          if (last_hs) begin
            state_q <= IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  tt_word_emitter #(
    .NWORDS (TT_BITS / WORD_W)
  ) u_emit (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .tbl     (table_d),
    .last_hs (last_hs),
    .wif     (wif)
  );

  assign x          = x_q;
  assign busy       = busy_q;
  assign ones_count = ones_q;
  assign done       = done_q;

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential harness stage that wraps a 7-input combinational classification function, such as a majority-gate network with inputs x0..x6 and output out.
- Upstream role: enumerates all 128 input vectors onto the function's inputs.
- Downstream role: samples the function output for each vector and assembles a 128-bit truth table.
- Streams the table out as four 32-bit words, most-significant word first, so the word sequence reads as the 32-hex-digit signature used to name and classify functions.
- Also reports the table's on-set size.

Parameters:
- NUM_INPUTS, 7, number of function inputs; fixed at 7 for this block, table depth is 2**NUM_INPUTS = 128.
- SETTLE_CYCLES, 1, extra cycles a vector is held before the output is sampled; legal range 0..15.
- WORD_W, 32, output word width; table is emitted in 128/WORD_W = 4 words.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- x  out  7  vector driven to the function; x[0] drives x0 ... x[6] drives x6. Registered.
- f_in  in  1  function output (out) for the current x.
- busy  out  1  high from the accepted start until the last word is accepted.
- word_valid  out  1  output word available.
- word_ready  in  1  consumer accepts the word.
- word_data  out  32  truth-table word.
- word_idx  out  2  index of the word; 3 = bits 127..96 is sent first, 0 is sent last.
- ones_count  out  8  number of 1s in the table, 0..128; stable from the first word_valid until the next start.
- done  out  1  one-cycle pulse, the cycle after word 0 is accepted.

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE, x=0, busy=0, word_valid=0, word_data=0, word_idx=3, ones_count=0, done=0, table=0, settle counter=0.
- States: IDLE, SETTLE, EMIT.
- IDLE:
  - start=1 -> SETTLE, x=0, settle counter=0, ones_count=0, busy=1.
  - start=0 -> remain in IDLE.
- SETTLE:
  - Each vector v is held for SETTLE_CYCLES+1 cycles.
  - On the clock edge ending the last of those cycles, f_in is written to table bit v, and ones_count increments if f_in=1.
  - If v=127 -> EMIT with word_idx=3. Otherwise x=v+1, counter=0.
  - Full sweep takes exactly 128*(SETTLE_CYCLES+1) cycles from the start edge to EMIT entry.
- Bit ordering: table bit index = {x6,x5,x4,x3,x2,x1,x0}, with x0 as LSB.
  - word k = table[32k+31 : 32k].
  - The hex digits of words 3,2,1,0 concatenated form the function's signature string.
- EMIT:
  - word_valid=1; word_data and word_idx are held stable while word_ready=0. No combinational path from word_ready to word_valid.
  - A handshake with word_idx>0 decrements word_idx.
  - A handshake with word_idx=0 returns to IDLE: word_valid=0, busy=0, done=1 for one cycle.
- x holds 127 during EMIT and returns to 0 in IDLE.
- start while busy is ignored, not queued.
- start in the same cycle done is asserted is accepted: FSM is already in IDLE.
- rst_n asserted mid-sweep or mid-EMIT: immediate return to reset values. The partial table is discarded and no word is emitted.
- ones_count cannot overflow: 8 bits covers 128.

Decomposition:
- Shared package tt_pkg holds:
  - state enum (IDLE, SETTLE, EMIT);
  - constants TT_BITS=128, TT_WORDS=4;
  - localparam function for the word slice.
- One natural sub-module: tt_word_emitter, which owns the EMIT-side valid/ready register slice and word_idx down-counter.
- The sweep counter, settle counter and table register stay in the top.

Test Plan:
- Stimulus: f_in = x[0], SETTLE_CYCLES=1, word_ready=1. Response:
  - words 0xAAAAAAAA x4 with word_idx 3,2,1,0;
  - ones_count=64;
  - done 256+4 cycles after start (one emit cycle per word plus the done cycle);
  - busy low the cycle done pulses.
- Stimulus: f_in = AND of x[6:0]. Response: word3=0x80000000, words 2..0 = 0x00000000, ones_count=1.
- Stimulus: f_in = bit-serial model of signature feeaeaa8eaa8aaa8eaaaeaa8eaa8a880, SETTLE_CYCLES=0. Response:
  - words 0xfeeaeaa8, 0xeaa8aaa8, 0xeaaaeaa8, 0xeaa8a880 in that order;
  - ones_count=64.
- Backpressure: word_ready low for 5 cycles on each word. Response: word_data/word_idx stable while stalled, no word skipped or duplicated, exactly 4 handshakes.
- start pulsed at cycle 10 of a sweep, and again in the done cycle. Response: the first is ignored with the sweep length unchanged; the second starts a new sweep with x=0 and ones_count=0.
- rst_n low at vector 60 for 1 cycle, then start. Response:
  - outputs at reset values asynchronously;
  - the subsequent sweep yields the correct full table with no residue from the aborted run.
